ttl245_bus_controller: RTL and testbench

- Synchronous initiator that owns the A side of a ttl245_transceiver.
- Sequences DIR, OE_n and the local A-side driver for single-word writes (A to B) and reads (B to A).
- Guarantees break-before-make so the A/B buses never see contention.
- Sits between Baby datapath logic and the 245 buffers on the store/IO bus.

---
 rtl/ttl_bus_pkg.sv | 25 ++
 rtl/ttl_bus_delay_counter.sv | 38 +++
 rtl/ttl245_bus_controller.sv | 149 ++++++++++++++
 tb/tb_ttl245_bus_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_bus_pkg.sv
// Shared types and constants for the 245 bus controller.
// Optional feature macro used by the controller: TTL245_READBACK_CHECK_EN.
package ttl_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_SETUP,
        ST_ACTIVE,
        ST_RECOVER
    } state_e;

    localparam logic DIR_A_TO_B  = 1'b1;
    localparam logic DIR_B_TO_A  = 1'b0;
    localparam logic OE_ENABLED  = 1'b0;
    localparam logic OE_DISABLED = 1'b1;

    // Counter width able to hold (max(a, b) - 1), never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ttl_bus_delay_counter.sv
// Loadable down-counter with a zero flag; times both the turnaround and the
// enable windows of the bus controller.
module ttl_bus_delay_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every signal written in always_comb is given a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ttl245_bus_controller.sv
// A-side initiator for a 245 transceiver: sequences DIR / OE_n / local driver
// with break-before-make. Define TTL245_READBACK_CHECK_EN for write readback checking.
module ttl245_bus_controller
    import ttl_bus_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int TURNAROUND_CYCLES = 1,
    parameter int ENABLE_CYCLES     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic             err,
    output logic [WIDTH-1:0] a_out,
    output logic             a_oe,
    input  logic [WIDTH-1:0] a_in,
    output logic             dir,
    output logic             oe_n
);

    localparam int CNT_W = cnt_width(TURNAROUND_CYCLES, ENABLE_CYCLES);
    localparam logic [CNT_W-1:0] TURN_LOAD =
        CNT_W'((TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ENABLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic               wr_q, wr_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   a_out_q, a_out_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               oe_n_q, a_oe_q, done_q, ready_q;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_zero;

    ttl_bus_delay_counter #(.W(CNT_W)) u_delay (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        dir_d        = dir_q;
        a_out_d      = a_out_q;
        rd_data_d    = rd_data_q;
        cnt_load     = 1'b0;
        cnt_load_val = TURN_LOAD;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    a_out_d = wr_data;
                    state_d = ST_SETUP;
                    // DIR flips here, while OE_n is still high from IDLE.
                    if (wr != dir_q) begin
                        dir_d = wr;
                        if (TURNAROUND_CYCLES > 0) begin
                            state_d  = ST_TURN;
                            cnt_load = 1'b1;
                        end
                    end
                end
            end
            ST_TURN: begin
                if (cnt_zero) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d      = ST_ACTIVE;
                cnt_load     = 1'b1;
                cnt_load_val = ACT_LOAD;
            end
            ST_ACTIVE: begin
                if (cnt_zero) begin
                    state_d = ST_RECOVER;
                    if (wr_q == DIR_B_TO_A) rd_data_d = a_in;
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            dir_q     <= DIR_B_TO_A;
            a_out_q   <= '0;
            rd_data_q <= '0;
            oe_n_q    <= OE_DISABLED;
            a_oe_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            dir_q     <= dir_d;
            a_out_q   <= a_out_d;
            rd_data_q <= rd_data_d;
            oe_n_q    <= (state_d == ST_ACTIVE) ? OE_ENABLED : OE_DISABLED;
            a_oe_q    <= wr_d && (state_d inside {ST_SETUP, ST_ACTIVE, ST_RECOVER});
            done_q    <= (state_d == ST_RECOVER);
            ready_q   <= (state_d == ST_IDLE);
        end
    end

`ifdef TTL245_READBACK_CHECK_EN
    logic err_q;
    logic accept;
    logic check_now;

    assign accept    = (state_q == ST_IDLE) && req;
    assign check_now = (state_q == ST_ACTIVE) && cnt_zero && (wr_q == DIR_A_TO_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (check_now && (a_in != a_out_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ready   = ready_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign a_out   = a_out_q;
    assign a_oe    = a_oe_q;
    assign dir     = dir_q;
    assign oe_n    = oe_n_q;

endmodule

// File: tb/tb_ttl245_bus_controller.sv
// Self-checking bench for ttl245_bus_controller with a behavioural 245 model;
// honours TTL245_READBACK_CHECK_EN for the err expectations.
module tb_ttl245_bus_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ready, done, err, a_oe, dir, oe_n;
    logic [7:0] rd_data, a_out, a_in;

    logic [7:0] b_drive = 8'h00;
    logic       a_force = 1'b0;
    logic [7:0] a_force_val = 8'h00;
    logic [7:0] a_bus, b_bus;

    int n_checks = 0;
    int n_fail = 0;
    int viol = 0;
    int done_total = 0;
    logic prev_dir = 1'b0;
    logic prev_oe_n = 1'b1;

`ifdef TTL245_READBACK_CHECK_EN
    localparam logic RB_EN = 1'b1;
`else
    localparam logic RB_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ttl245_bus_controller dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .wr_data (wr_data),
        .ready   (ready),
        .done    (done),
        .rd_data (rd_data),
        .err     (err),
        .a_out   (a_out),
        .a_oe    (a_oe),
        .a_in    (a_in),
        .dir     (dir),
        .oe_n    (oe_n)
    );

    // Behavioural 245 plus bus: B driven from A when enabled A->B, A driven from B when enabled B->A.
    always_comb begin
        if (a_force)                a_bus = a_force_val;
        else if (a_oe)              a_bus = a_out;
        else if (!oe_n && !dir)     a_bus = b_drive;
        else                        a_bus = 8'h00;
        b_bus = (!oe_n && dir) ? a_bus : 8'h00;
    end
    assign a_in = a_bus;

    always @(negedge clk) begin
        if (!reset) begin
            if (!oe_n && !dir && a_oe) viol++;
            if (a_oe && !dir) viol++;
            if ((dir !== prev_dir) && (!oe_n || !prev_oe_n)) viol++;
            if (done) done_total++;
        end
        prev_dir  = dir;
        prev_oe_n = oe_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at a negedge in IDLE; returns at the negedge after done (back in IDLE).
    task automatic do_xfer(input logic w, input logic [7:0] d, input logic [7:0] bv,
                           output int lat, output int first_lo, output int oe_lo,
                           output logic [7:0] bseen, output logic a_oe_seen);
        b_drive = bv;
        req = 1'b1; wr = w; wr_data = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 0; first_lo = 0; oe_lo = 0; bseen = 8'h00; a_oe_seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!oe_n) begin
                oe_lo++;
                if (first_lo == 0) first_lo = i;
                if (dir) bseen = b_bus;
            end
            if (a_oe) a_oe_seen = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] bval;
        int         lat;
        int         first_lo;
        logic [7:0] rd;
        logic [7:0] b;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, first_lo, oe_lo;
        logic [7:0] bseen, b1, b2;
        logic a_oe_seen, saw_done;
        int n_done, d1, d2;

        vecs[0] = '{1'b1, 8'h11, 8'h00, 5, 3, 8'h00, 8'h11};
        vecs[1] = '{1'b1, 8'hAA, 8'h00, 4, 2, 8'h00, 8'hAA};
        vecs[2] = '{1'b0, 8'h00, 8'h3C, 5, 3, 8'h3C, 8'h00};
        vecs[3] = '{1'b1, 8'hF0, 8'h00, 5, 3, 8'h3C, 8'hF0};
        vecs[4] = '{1'b0, 8'h00, 8'h55, 5, 3, 8'h55, 8'h00};
        vecs[5] = '{1'b1, 8'hCC, 8'h00, 5, 3, 8'h55, 8'hCC};
        vecs[6] = '{1'b0, 8'h00, 8'h81, 5, 3, 8'h81, 8'h00};
        vecs[7] = '{1'b0, 8'h00, 8'h7E, 4, 2, 8'h7E, 8'h00};
        vecs[8] = '{1'b1, 8'h01, 8'h00, 5, 3, 8'h7E, 8'h01};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_a_oe", a_oe, 0);
        check("rst_dir", dir, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_a_out", a_out, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready, 1);

        // Table of single transfers
        foreach (vecs[k]) begin
            do_xfer(vecs[k].wr, vecs[k].wdata, vecs[k].bval, lat, first_lo, oe_lo, bseen, a_oe_seen);
            check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
            check($sformatf("v%0d_first_oe_low", k), first_lo, vecs[k].first_lo);
            check($sformatf("v%0d_oe_low_cycles", k), oe_lo, 2);
            check($sformatf("v%0d_rd_data", k), rd_data, vecs[k].rd);
            check($sformatf("v%0d_dir", k), dir, vecs[k].wr);
            check($sformatf("v%0d_ready", k), ready, 1);
            if (vecs[k].wr) check($sformatf("v%0d_b_bus", k), bseen, vecs[k].b);
            else            check($sformatf("v%0d_a_oe_seen", k), a_oe_seen, 0);
        end

        // Held request plus data change while busy
        b1 = 8'h00; b2 = 8'h00; n_done = 0; d1 = 0; d2 = 0;
        req = 1'b1; wr = 1'b1; wr_data = 8'h5A;
        @(posedge clk);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 2) begin
                check("busy_ready_low", ready, 0);
                wr_data = 8'h3C;
            end
            if (j == 5) check("busy_ready_idle", ready, 1);
            if (!oe_n && dir) begin
                if (j <= 4) b1 = b_bus;
                else        b2 = b_bus;
            end
            if (done) begin
                n_done++;
                if (d1 == 0) d1 = j;
                else         d2 = j;
            end
            if (j == 10) req = 1'b0;
        end
        check("busy_done_count", n_done, 2);
        check("busy_done1_pos", d1, 4);
        check("busy_done2_pos", d2, 9);
        check("busy_b_first", b1, 8'h5A);
        check("busy_b_second", b2, 8'h3C);

        // Asynchronous reset in the middle of ACTIVE
        req = 1'b1; wr = 1'b1; wr_data = 8'hE7;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("arst_pre_oe_n", oe_n, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_oe_n", oe_n, 1);
        check("arst_a_oe", a_oe, 0);
        check("arst_dir", dir, 0);
        check("arst_done", done, 0);
        saw_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("arst_no_done", saw_done, 0);
        check("arst_ready", ready, 1);
        check("arst_dir_hold", dir, 0);

        // Readback: A bus held at 00 while writing FF
        a_force = 1'b1; a_force_val = 8'h00;
        do_xfer(1'b1, 8'hFF, 8'h00, lat, first_lo, oe_lo, bseen, a_oe_seen);
        a_force = 1'b0;
        check("rb_latency", lat, 5);
        check("rb_err_set", err, RB_EN);
        repeat (3) @(negedge clk);
        check("rb_err_sticky", err, RB_EN);
        req = 1'b1; wr = 1'b1; wr_data = 8'h12;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rb_err_clear", err, 0);
        lat = 0; bseen = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            if (!oe_n && dir) bseen = b_bus;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check("rb_next_latency", lat, 4);
        check("rb_next_b_bus", bseen, 8'h12);
        check("rb_next_err", err, 0);
        repeat (2) @(negedge clk);

        check("invariant_violations", viol, 0);
        check("done_total", done_total, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
